// File: rtl/intpol2_iq_seq.sv
// Sequencer for the 2nd-order IQ interpolator datapath.
// Each I/Q pair is popped from the input FIFOs in lockstep and loaded into the
// interpolator. The sequencer then issues L interpolation steps for the pair,
// pausing whenever either output FIFO is almost full. A done pulse and a sticky
// interrupt request mark the end of a run.
module intpol2_iq_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH_W    = 8,
   parameter int FACTOR_W   = 4
) (
   input  logic                        clk,
   input  logic                        rst_a,
   input  logic                        start_i,
   input  logic [DEPTH_W-1:0]          cfg_depth_i,
   input  logic [FACTOR_W-1:0]         cfg_factor_i,
   input  logic                        empty_I_i,
   input  logic                        empty_Q_i,
   output logic                        rd_en_o,
   input  logic [DATA_WIDTH-1:0]       data_I_i,
   input  logic [DATA_WIDTH-1:0]       data_Q_i,
   input  logic                        afull_I_i,
   input  logic                        afull_Q_i,
   output logic                        smp_valid_o,
   output logic [DATA_WIDTH-1:0]       smp_I_o,
   output logic [DATA_WIDTH-1:0]       smp_Q_o,
   output logic                        step_o,
   output logic [FACTOR_W-1:0]         step_idx_o,
   output logic                        wr_en_o,
   output logic [DEPTH_W+FACTOR_W-1:0] out_cnt_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        int_req_o,
   input  logic                        int_ack_i
);

   localparam int OUT_W = DEPTH_W + FACTOR_W;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      INTERP,
      FINISH
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [DEPTH_W-1:0]   depth_q;
   logic [DEPTH_W-1:0]   in_cnt;
   logic [FACTOR_W-1:0]  factor_q;
   logic [FACTOR_W-1:0]  phase;
   logic                 zero_done_q;
   logic                 start_run;
   logic                 start_zero;
   logic                 pop_ok;
   logic                 step_ok;
   logic                 last_phase;
   logic                 last_pair;

   // Both FIFOs must have data before they are popped together, and any
   // almost-full output FIFO stalls the step.
   assign start_run  = (state == IDLE) && start_i && (cfg_depth_i != '0);
   assign start_zero = (state == IDLE) && start_i && (cfg_depth_i == '0);
   assign pop_ok     = !empty_I_i && !empty_Q_i;
   assign step_ok    = !(afull_I_i || afull_Q_i);
   assign last_phase = (phase == factor_q - FACTOR_W'(1));
   assign last_pair  = (in_cnt == depth_q - DEPTH_W'(1));

   assign step_idx_o = step_o ? phase : '0;
   assign busy_o     = (state != IDLE);
   assign done_o     = (state == FINISH) || zero_done_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst_a) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and the per-state strobes.
   always_comb begin
      state_nxt   = state;
      rd_en_o     = 1'b0;
      smp_valid_o = 1'b0;
      step_o      = 1'b0;
      case (state)
         IDLE: begin
            if (start_run) begin
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            rd_en_o = pop_ok;
            if (pop_ok) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            smp_valid_o = 1'b1;
            state_nxt   = INTERP;
         end
         INTERP: begin
            step_o = step_ok;
            if (step_ok && last_phase) begin
               state_nxt = last_pair ? FINISH : FETCH;
            end
         end
         FINISH: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Run configuration, pair counter and phase counter. A factor of 0 runs as 1.
   always_ff @(posedge clk) begin
      if (rst_a) begin
         depth_q     <= '0;
         factor_q    <= '0;
         in_cnt      <= '0;
         phase       <= '0;
         zero_done_q <= 1'b0;
      end else begin
         zero_done_q <= start_zero;
         if (start_run) begin
            depth_q  <= cfg_depth_i;
            factor_q <= (cfg_factor_i == '0) ? FACTOR_W'(1) : cfg_factor_i;
            in_cnt   <= '0;
         end else if (step_o && last_phase && !last_pair) begin
            in_cnt <= in_cnt + DEPTH_W'(1);
         end
         if (state == LOAD) begin
            phase <= '0;
         end else if (step_o) begin
            phase <= phase + FACTOR_W'(1);
         end
      end
   end

   // Capture the popped pair; FIFO read data is valid in the LOAD cycle.
   always_ff @(posedge clk) begin
      if (rst_a) begin
         smp_I_o <= '0;
         smp_Q_o <= '0;
      end else if (state == LOAD) begin
         smp_I_o <= data_I_i;
         smp_Q_o <= data_Q_i;
      end
   end

   // Output FIFO write follows each step by the interpolator's one-cycle latency.
   always_ff @(posedge clk) begin
      if (rst_a) begin
         wr_en_o   <= 1'b0;
         out_cnt_o <= '0;
      end else begin
         wr_en_o <= step_o;
         if (start_run) begin
            out_cnt_o <= '0;
         end else if (wr_en_o) begin
            out_cnt_o <= out_cnt_o + OUT_W'(1);
         end
      end
   end

   // Sticky interrupt; a new completion wins over a simultaneous acknowledge.
   always_ff @(posedge clk) begin
      if (rst_a) begin
         int_req_o <= 1'b0;
      end else if ((state == FINISH) || start_zero) begin
         int_req_o <= 1'b1;
      end else if (int_ack_i) begin
         int_req_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_intpol2_iq_seq.sv
// Testbench for intpol2_iq_seq: models the input FIFOs as queues, expects the
// step/phase sequence and sample values from the run configuration, and checks
// timing of completion for unstalled and deliberately stalled runs.
module tb_intpol2_iq_seq;

   localparam int DW       = 32;
   localparam int DEPTH_W  = 8;
   localparam int FACTOR_W = 4;
   localparam int OUT_W    = DEPTH_W + FACTOR_W;

   logic                clk = 1'b0;
   logic                rst_a;
   logic                start_i;
   logic [DEPTH_W-1:0]  cfg_depth_i;
   logic [FACTOR_W-1:0] cfg_factor_i;
   logic                empty_I_i;
   logic                empty_Q_i;
   logic                rd_en_o;
   logic [DW-1:0]       data_I_i;
   logic [DW-1:0]       data_Q_i;
   logic                afull_I_i;
   logic                afull_Q_i;
   logic                smp_valid_o;
   logic [DW-1:0]       smp_I_o;
   logic [DW-1:0]       smp_Q_o;
   logic                step_o;
   logic [FACTOR_W-1:0] step_idx_o;
   logic                wr_en_o;
   logic [OUT_W-1:0]    out_cnt_o;
   logic                busy_o;
   logic                done_o;
   logic                int_req_o;
   logic                int_ack_i;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] fifo_i[$];
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] pair_i[$];
   logic [DW-1:0] pair_q[$];

   intpol2_iq_seq #(
      .DATA_WIDTH(DW),
      .DEPTH_W(DEPTH_W),
      .FACTOR_W(FACTOR_W)
   ) dut (
      .clk(clk),
      .rst_a(rst_a),
      .start_i(start_i),
      .cfg_depth_i(cfg_depth_i),
      .cfg_factor_i(cfg_factor_i),
      .empty_I_i(empty_I_i),
      .empty_Q_i(empty_Q_i),
      .rd_en_o(rd_en_o),
      .data_I_i(data_I_i),
      .data_Q_i(data_Q_i),
      .afull_I_i(afull_I_i),
      .afull_Q_i(afull_Q_i),
      .smp_valid_o(smp_valid_o),
      .smp_I_o(smp_I_o),
      .smp_Q_o(smp_Q_o),
      .step_o(step_o),
      .step_idx_o(step_idx_o),
      .wr_en_o(wr_en_o),
      .out_cnt_o(out_cnt_o),
      .busy_o(busy_o),
      .done_o(done_o),
      .int_req_o(int_req_o),
      .int_ack_i(int_ack_i)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Safety net in case a wait somewhere never completes.
   initial begin
      #5ms;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Every output of the sequencer must be zero after reset.
   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ctrl"},
                  {rd_en_o, smp_valid_o, step_o, wr_en_o, busy_o, done_o, int_req_o}, 0);
      checkOutput({tag, "_smp_I"}, smp_I_o, 0);
      checkOutput({tag, "_smp_Q"}, smp_Q_o, 0);
      checkOutput({tag, "_idx"}, step_idx_o, 0);
      checkOutput({tag, "_out_cnt"}, out_cnt_o, 0);
   endtask

   // Acknowledge any pending interrupt so each run starts from a known state.
   task automatic clearIrq();
      @(posedge clk); #1;
      int_ack_i = 1'b1;
      @(posedge clk); #1;
      int_ack_i = 1'b0;
      @(negedge clk);
      checkOutput("irq_cleared", int_req_o, 0);
   endtask

   // One run. afull_mode: 0 none, 1 random, 2 hold afull_Q 3 cycles after the
   // 2nd step. empty_mode: 0 queue-driven, 1 random extra empties, 2 Q empty in
   // relative cycles 1..5. exp_done_rel < 0 skips the completion-time check;
   // reset_rel >= 0 resets the design in that relative cycle and ends the run.
   task automatic applyStimulus(input int depth, input int factor, input int afull_mode,
                                input int empty_mode, input int ack_mode,
                                input int exp_done_rel, input int reset_rel);
      int            l_eff;
      int            total;
      int            steps;
      int            writes;
      int            pops;
      int            done_rel;
      int            afull_left;
      int            p;
      bit            done_seen;
      bit            pending;
      logic          prev_step;
      logic          prev_rd;
      logic          last_busy;
      logic          last_done;
      logic          int_exp;
      logic [DW-1:0] pend_i;
      logic [DW-1:0] pend_q;

      l_eff      = (factor == 0) ? 1 : factor;
      total      = depth * l_eff;
      steps      = 0;
      writes     = 0;
      pops       = 0;
      done_rel   = -1;
      afull_left = 0;
      done_seen  = 1'b0;
      pending    = 1'b0;
      prev_step  = 1'b0;
      prev_rd    = 1'b0;
      last_busy  = 1'b0;
      last_done  = 1'b0;
      int_exp    = 1'b0;
      pend_i     = '0;
      pend_q     = '0;
      fifo_i.delete();
      fifo_q.delete();
      pair_i.delete();
      pair_q.delete();
      for (int k = 0; k < depth + 2; k++) begin
         fifo_i.push_back($urandom);
         fifo_q.push_back($urandom);
      end

      for (int rel = 0; rel < 20000; rel++) begin
         @(posedge clk); #1;
         if (rel == 0) begin
            start_i      = 1'b1;
            cfg_depth_i  = DEPTH_W'(depth);
            cfg_factor_i = FACTOR_W'(factor);
         end else begin
            start_i      = last_busy && !last_done && ($urandom_range(0, 4) == 0);
            cfg_depth_i  = DEPTH_W'($urandom);
            cfg_factor_i = FACTOR_W'($urandom);
         end
         rst_a = (rel == reset_rel);
         if (pending) begin
            data_I_i = pend_i;
            data_Q_i = pend_q;
            pending  = 1'b0;
         end else begin
            data_I_i = $urandom;
            data_Q_i = $urandom;
         end
         empty_I_i = (fifo_i.size() == 0);
         empty_Q_i = (fifo_q.size() == 0);
         if (empty_mode == 1) begin
            empty_I_i = empty_I_i || ($urandom_range(0, 3) == 0);
            empty_Q_i = empty_Q_i || ($urandom_range(0, 3) == 0);
         end else if (empty_mode == 2 && rel >= 1 && rel <= 5) begin
            empty_Q_i = 1'b1;
         end
         afull_I_i = 1'b0;
         afull_Q_i = 1'b0;
         if (afull_mode == 1) begin
            afull_I_i = ($urandom_range(0, 3) == 0);
            afull_Q_i = ($urandom_range(0, 3) == 0);
         end else if (afull_mode == 2 && afull_left > 0) begin
            afull_Q_i  = 1'b1;
            afull_left = afull_left - 1;
         end
         int_ack_i = (ack_mode != 0);

         if (rel == reset_rel) begin
            @(posedge clk); #1;
            rst_a     = 1'b0;
            start_i   = 1'b0;
            int_ack_i = 1'b0;
            @(negedge clk);
            checkAllZero("reset_midrun");
            return;
         end

         @(negedge clk);
         checkOutput("smp_valid", smp_valid_o, prev_rd);
         if (rd_en_o) begin
            checkOutput("pop_needs_both", {empty_I_i, empty_Q_i}, 0);
            if (fifo_i.size() == 0 || fifo_q.size() == 0) begin
               checkOutput("pop_underflow", 1, 0);
            end else begin
               pend_i  = fifo_i.pop_front();
               pend_q  = fifo_q.pop_front();
               pair_i.push_back(pend_i);
               pair_q.push_back(pend_q);
               pending = 1'b1;
            end
            pops++;
         end
         if (step_o) begin
            checkOutput("step_no_afull", {afull_I_i, afull_Q_i}, 0);
            if (steps >= total) begin
               checkOutput("step_excess", steps, total - 1);
            end else begin
               checkOutput("step_idx", step_idx_o, steps % l_eff);
               p = steps / l_eff;
               if (p < pair_i.size()) begin
                  checkOutput("smp_I", smp_I_o, pair_i[p]);
                  checkOutput("smp_Q", smp_Q_o, pair_q[p]);
               end else begin
                  checkOutput("step_before_pop", p, pair_i.size());
               end
            end
            steps++;
            if (steps == 2 && afull_mode == 2) begin
               afull_left = 3;
            end
         end
         checkOutput("wr_en", wr_en_o, prev_step);
         if (rel > 0) begin
            checkOutput("out_cnt", out_cnt_o, writes);
         end
         if (wr_en_o) begin
            writes++;
         end
         checkOutput("busy", busy_o, (rel >= 1) && !done_seen);
         checkOutput("int_req", int_req_o, int_exp);
         int_exp = done_o ? 1'b1 : (int_ack_i ? 1'b0 : int_exp);

         if (done_seen) begin
            checkOutput("done_single", done_o, 0);
            checkOutput("final_out_cnt", out_cnt_o, total);
            checkOutput("fifo_left_I", fifo_i.size(), 2);
            checkOutput("fifo_left_Q", fifo_q.size(), 2);
            break;
         end
         if (done_o) begin
            done_seen = 1'b1;
            done_rel  = rel;
            checkOutput("done_steps", steps, total);
            checkOutput("done_pops", pops, depth);
            if (exp_done_rel >= 0) begin
               checkOutput("done_cycle", rel, exp_done_rel);
            end
         end
         prev_step = step_o;
         prev_rd   = rd_en_o;
         last_busy = busy_o;
         last_done = done_o;
      end

      start_i   = 1'b0;
      int_ack_i = 1'b0;
      if (!done_seen) begin
         checkOutput("done_timeout", 0, 1);
      end
   endtask

   // Start with depth 0: immediate done and interrupt, nothing popped.
   task automatic zeroDepthRun();
      @(posedge clk); #1;
      start_i      = 1'b1;
      cfg_depth_i  = '0;
      cfg_factor_i = FACTOR_W'(3);
      @(negedge clk);
      checkOutput("zero_pre_done", done_o, 0);
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      checkOutput("zero_done", done_o, 1);
      checkOutput("zero_no_pop", rd_en_o, 0);
      checkOutput("zero_busy", busy_o, 0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("zero_done_pulse", done_o, 0);
      checkOutput("zero_int_req", int_req_o, 1);
      checkOutput("zero_no_pop2", rd_en_o, 0);
   endtask

   initial begin
      rst_a        = 1'b1;
      start_i      = 1'b0;
      cfg_depth_i  = '0;
      cfg_factor_i = '0;
      empty_I_i    = 1'b1;
      empty_Q_i    = 1'b1;
      data_I_i     = '0;
      data_Q_i     = '0;
      afull_I_i    = 1'b0;
      afull_Q_i    = 1'b0;
      int_ack_i    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkAllZero("reset");
      @(posedge clk); #1;
      rst_a = 1'b0;

      $display("[TB] basic run depth=4 L=2");
      clearIrq();
      applyStimulus(4, 2, 0, 0, 0, 17, -1);

      $display("[TB] backpressure depth=1 L=4");
      clearIrq();
      applyStimulus(1, 4, 2, 0, 0, 10, -1);

      $display("[TB] empty stall depth=1 L=2");
      clearIrq();
      applyStimulus(1, 2, 0, 2, 0, 10, -1);

      $display("[TB] depth=0 start");
      clearIrq();
      zeroDepthRun();

      $display("[TB] L=0 with depth=2");
      clearIrq();
      applyStimulus(2, 0, 0, 0, 0, 7, -1);

      $display("[TB] ack held through completion");
      clearIrq();
      applyStimulus(3, 3, 0, 0, 1, 16, -1);

      $display("[TB] reset mid-run then fresh start");
      clearIrq();
      applyStimulus(10, 3, 0, 0, 0, -1, 10);
      applyStimulus(10, 3, 0, 0, 0, 51, -1);

      $display("[TB] maximum depth and factor");
      clearIrq();
      applyStimulus(255, 15, 0, 0, 0, 4336, -1);

      $display("[TB] randomized runs");
      for (int r = 0; r < 12; r++) begin
         clearIrq();
         applyStimulus($urandom_range(1, 20), $urandom_range(0, 15), 1, 1, r % 2, -1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/intpol2_iq_seq.md
Name: intpol2_iq_seq

Overview:
Sequencer for the 2nd-order IQ interpolator datapath.
- Pops I/Q sample pairs in lockstep from the input FIFOs and loads each pair into the interpolator.
- Issues L interpolation steps per loaded pair, honouring almost-full backpressure from the I/Q output FIFOs (Sink side).
- Counts processed samples and signals completion with a done pulse and a sticky interrupt request.

Parameters:
DATA_WIDTH, 32, width of the I and Q sample buses.
DEPTH_W, 8, width of the input-pair count (data_depth).
FACTOR_W, 4, width of the interpolation factor L and the phase index.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_a  input  1  reset, synchronous, active-high
start_i  input  1  start request, sampled only in IDLE
cfg_depth_i  input  DEPTH_W  number of I/Q input pairs to process, latched on accepted start
cfg_factor_i  input  FACTOR_W  interpolation factor L (outputs per input pair), latched on start; 0 treated as 1
empty_I_i  input  1  I input FIFO empty
empty_Q_i  input  1  Q input FIFO empty
rd_en_o  output  1  pop both input FIFOs; read data valid 1 cycle later
data_I_i  input  DATA_WIDTH  I FIFO read data
data_Q_i  input  DATA_WIDTH  Q FIFO read data
afull_I_i  input  1  I output FIFO almost full
afull_Q_i  input  1  Q output FIFO almost full
smp_valid_o  output  1  1-cycle load strobe to interpolator
smp_I_o  output  DATA_WIDTH  registered I sample to interpolator
smp_Q_o  output  DATA_WIDTH  registered Q sample to interpolator
step_o  output  1  interpolator compute-one-output strobe
step_idx_o  output  FACTOR_W  phase index 0..L-1 accompanying step_o
wr_en_o  output  1  output FIFO write (I and Q), step_o delayed 1 cycle
out_cnt_o  output  DEPTH_W+FACTOR_W  total outputs written since last start
busy_o  output  1  high in any state except IDLE
done_o  output  1  1-cycle completion pulse
int_req_o  output  1  sticky interrupt, cleared by int_ack_i
int_ack_i  input  1  interrupt acknowledge

Behaviour:
- Reset (rst_a=1 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0, including smp_I_o/smp_Q_o, out_cnt_o and int_req_o.
  - Reset mid-operation aborts the run immediately. No done_o, no int_req_o.
- States: IDLE, FETCH, LOAD, INTERP, FINISH.
- IDLE:
  - start_i=1 with cfg_depth_i≠0: latch depth and L (L=1 if cfg_factor_i=0), clear the input counter and out_cnt_o, go to FETCH.
  - start_i=1 with cfg_depth_i=0: assert done_o for 1 cycle, set int_req_o, stay in IDLE.
- FETCH:
  - rd_en_o = !empty_I_i && !empty_Q_i (combinational from state).
  - If rd_en_o=1, go to LOAD; otherwise wait in FETCH.
  - The FIFOs are never popped singly.
- LOAD:
  - Register data_I_i/data_Q_i into smp_I_o/smp_Q_o.
  - Assert smp_valid_o for this cycle, reset the phase to 0, go to INTERP.
- INTERP:
  - step_o = !(afull_I_i || afull_Q_i), with step_idx_o = phase.
  - On each step the phase increments.
  - Step with phase = L-1 and input counter = depth-1: go to FINISH.
  - Step with phase = L-1 otherwise: increment the input counter and go to FETCH.
  - Backpressure holds the phase and state. No step is lost or duplicated.
- wr_en_o equals step_o registered by 1 cycle (interpolator latency = 1). out_cnt_o increments on each wr_en_o.
- FINISH:
  - 1 cycle long; the final wr_en_o occurs in this cycle.
  - done_o=1 during this cycle.
  - On exit, int_req_o is set and the state goes to IDLE.
- start_i while busy_o=1 is ignored.
- int_req_o: set has priority over int_ack_i in the same cycle. int_ack_i with int_req_o=0 has no effect.
- Throughput: L+2 cycles per input pair when unstalled.
- Counter widths hold their maximum values without wrap: depth up to 2^DEPTH_W-1, out_cnt_o up to (2^DEPTH_W-1)·(2^FACTOR_W-1).

Test Plan:
- Basic run: depth=4, L=2, FIFOs pre-filled, no afull, start_i at edge 0 -> FETCH in cycle 1; rd_en_o in cycles 1,5,9,13; 8 step_o with step_idx_o 0,1,0,1,…; done_o in cycle 17; int_req_o high from cycle 18; out_cnt_o=8.
- Backpressure: depth=1, L=4, afull_Q_i=1 for 3 cycles after the 2nd step -> exactly 4 steps with idx 0,1,2,3 and no duplicate; done_o is delayed by 3 cycles versus the unstalled run.
- Empty stall: empty_I_i=0 but empty_Q_i=1 for 5 cycles in FETCH -> rd_en_o stays 0; a single pop occurs when both are non-empty; smp_I_o/smp_Q_o match the FIFO heads.
- Edge config: depth=0 -> done_o 1 cycle after start, no rd_en_o, int_req_o set. L=0 with depth=2 -> behaves as L=1 (2 steps, out_cnt_o=2).
- Interrupt and restart: int_ack_i and set in the same cycle -> int_req_o remains 1. start_i while busy_o=1 -> ignored, counters unaffected.
- Reset mid-run: rst_a=1 during INTERP of depth=10, L=3 -> next cycle all outputs 0 and state IDLE; a fresh start completes with out_cnt_o=30.
